// File: rtl/left_shift_pkg.sv
// left_shift_pkg: shared definitions for the left_shift register slice.
//   DEFAULT_WIDTH - default register width
//   op_e          - decoded per-cycle operation (load beats shift beats hold)
//   decode_op     - priority decode of the load/shift request pair
package left_shift_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_SHIFT = 2'd2
  } op_e;

  // load wins when both requests are high in the same cycle
  function automatic op_e decode_op(input logic load, input logic shift);
    if (load)       return OP_LOAD;
    else if (shift) return OP_SHIFT;
    else            return OP_HOLD;
  endfunction

endpackage

// File: rtl/left_shift_if.sv
// left_shift_if: request/data bundle for the left_shift register.
//   load, shift - single-cycle level requests (master -> slave)
//   data_in     - parallel load value        (master -> slave)
//   data_out    - current register contents  (slave -> master)
interface left_shift_if #(
  parameter int WIDTH = left_shift_pkg::DEFAULT_WIDTH
);
  logic             load;
  logic             shift;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;

  modport master (output load, output shift, output data_in, input data_out);
  modport slave  (input load, input shift, input data_in, output data_out);
endinterface

// File: rtl/left_shift_next.sv
// left_shift_next: combinational next-state for the left_shift register.
//   op      - decoded operation
//   cur     - current register value
//   data_in - parallel load value
//   nxt     - value to register at the next clock edge
// Build option: LEFT_SHIFT_ROTATE_EN makes a shift rotate (MSB wraps to
// LSB); otherwise the shift is logical and the LSB fills with zero.
module left_shift_next
  import left_shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] nxt
);

  logic fill;

`ifdef LEFT_SHIFT_ROTATE_EN
  assign fill = cur[WIDTH-1];
`else
  assign fill = 1'b0;
`endif

  always_comb begin
    nxt = cur;
    case (op)
      OP_LOAD:  nxt = data_in;
      OP_SHIFT: nxt = {cur[WIDTH-2:0], fill};
      default:  nxt = cur;
    endcase
  end

endmodule

// File: rtl/left_shift.sv
// left_shift: parallel-load, shift-left register.
//   clk   - clock, all updates on rising edge
//   reset - asynchronous active-high reset, forces RESET_VAL
//   bus   - left_shift_if.slave: load, shift, data_in in; data_out out
// data_out is the register itself: one cycle latency, no comb path from
// inputs. Build option LEFT_SHIFT_ROTATE_EN selects rotate instead of
// logical shift (see left_shift_next).
module left_shift
  import left_shift_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic        clk,
  input  logic        reset,
  left_shift_if.slave bus
);

  op_e              op;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;

  assign op = decode_op(bus.load, bus.shift);

  left_shift_next #(.WIDTH(WIDTH)) u_next (
    .op      (op),
    .cur     (q),
    .data_in (bus.data_in),
    .nxt     (q_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= RESET_VAL;
    else       q <= q_nxt;
  end

  assign bus.data_out = q;

endmodule

// File: tb/tb_left_shift.sv
// tb_left_shift: self-checking bench for left_shift (WIDTH=8, RESET_VAL=0).
// Inputs change and outputs are sampled on the falling edge; the reference
// model updates at each rising edge from the request rules.
module tb_left_shift;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] model;

  left_shift_if #(.WIDTH(W)) bus ();

  left_shift #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference shift: multiply by two modulo 2^W, optionally wrapping the MSB
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v);
    int unsigned x;
    x = (int'(v) * 2) % (1 << W);
`ifdef LEFT_SHIFT_ROTATE_EN
    if (v >= (1 << (W-1))) x = x + 1;
`endif
    return W'(x);
  endfunction

  // one clock: present requests now (at negedge), model the edge, return at next negedge
  task automatic cycle(input logic ld, input logic sh, input logic [W-1:0] din);
    bus.load    = ld;
    bus.shift   = sh;
    bus.data_in = din;
    @(posedge clk);
    if (!reset) begin
      if (ld)      model = din;
      else if (sh) model = ref_shift(model);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.load = 1'b0; bus.shift = 1'b0; bus.data_in = 8'hFF;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.data_out !== 8'h00) begin
      errors++; $display("FAIL reset_async: got %h exp %h", bus.data_out, 8'h00);
    end
    #10;
    @(negedge clk);
    checks++;
    if (bus.data_out !== 8'h00) begin
      errors++; $display("FAIL reset_held: got %h exp %h", bus.data_out, 8'h00);
    end
    reset = 1'b0;
    model = '0;
    cycle(1'b0, 1'b0, 8'hFF);
    checks++;
    if (bus.data_out !== 8'h00) begin
      errors++; $display("FAIL reset_release: got %h exp %h", bus.data_out, 8'h00);
    end
  endtask

  task automatic test_load();
    cycle(1'b1, 1'b0, 8'b01100101);
    checks++;
    if (bus.data_out !== 8'b01100101) begin
      errors++; $display("FAIL load: got %b exp %b", bus.data_out, 8'b01100101);
    end
    cycle(1'b0, 1'b0, 8'h00);
    checks++;
    if (bus.data_out !== 8'b01100101) begin
      errors++; $display("FAIL hold: got %b exp %b", bus.data_out, 8'b01100101);
    end
  endtask

  task automatic test_shift();
    logic [W-1:0] e1, e2;
    cycle(1'b1, 1'b0, 8'b01100101);
    e1 = 8'b11001010;
`ifdef LEFT_SHIFT_ROTATE_EN
    e2 = 8'b10010101;
`else
    e2 = 8'b10010100;
`endif
    cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (bus.data_out !== e1) begin
      errors++; $display("FAIL shift1: got %b exp %b", bus.data_out, e1);
    end
    cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (bus.data_out !== e2) begin
      errors++; $display("FAIL shift2: got %b exp %b", bus.data_out, e2);
    end
  endtask

  task automatic test_priority();
    cycle(1'b1, 1'b0, 8'h0F);
    cycle(1'b1, 1'b1, 8'hA5);
    checks++;
    if (bus.data_out !== 8'hA5) begin
      errors++; $display("FAIL priority: got %h exp %h", bus.data_out, 8'hA5);
    end
  endtask

  task automatic test_drain();
    logic [W-1:0] e1, e8;
`ifdef LEFT_SHIFT_ROTATE_EN
    e1 = 8'h03; e8 = 8'h81;
`else
    e1 = 8'h02; e8 = 8'h00;
`endif
    cycle(1'b1, 1'b0, 8'h81);
    cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (bus.data_out !== e1) begin
      errors++; $display("FAIL drain_1: got %h exp %h", bus.data_out, e1);
    end
    for (int i = 1; i < 8; i++) cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (bus.data_out !== e8) begin
      errors++; $display("FAIL drain_8: got %h exp %h", bus.data_out, e8);
    end
    // one more shift: zeros stay zero (or the rotation continues)
    cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (bus.data_out !== model) begin
      errors++; $display("FAIL drain_9: got %h exp %h", bus.data_out, model);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 8'hC3);
    cycle(1'b0, 1'b1, 8'h00);
    bus.shift = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.data_out !== 8'h00) begin
      errors++; $display("FAIL reset_midshift: got %h exp %h", bus.data_out, 8'h00);
    end
    bus.load = 1'b1; bus.data_in = 8'h5A;
    @(negedge clk);
    checks++;
    if (bus.data_out !== 8'h00) begin
      errors++; $display("FAIL reset_overrides_load: got %h exp %h", bus.data_out, 8'h00);
    end
    reset = 1'b0;
    model = '0;
    cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (bus.data_out !== model) begin
      errors++; $display("FAIL reset_then_shift: got %h exp %h", bus.data_out, model);
    end
  endtask

  task automatic test_random();
    logic         ld, sh;
    logic [W-1:0] din;
    for (int i = 0; i < 300; i++) begin
      ld  = ($urandom_range(0, 3) == 0);
      sh  = ($urandom_range(0, 1) == 1);
      din = W'($urandom);
      cycle(ld, sh, din);
      checks++;
      if (bus.data_out !== model) begin
        errors++;
        $display("FAIL random[%0d] ld=%b sh=%b din=%h: got %h exp %h",
                 i, ld, sh, din, bus.data_out, model);
      end
    end
  endtask

  initial begin
    bus.load = 1'b0; bus.shift = 1'b0; bus.data_in = '0;
    model = '0;
    test_reset();
    test_load();
    test_shift();
    test_priority();
    test_drain();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
